// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, state encoding and datapath select codes for the sequencer
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [1:0] SRC_MEM = 2'd0;
    localparam logic [1:0] SRC_ALU = 2'd1;
    localparam logic [1:0] SRC_IMM = 2'd2;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;

    typedef struct packed {
        logic       is_mem;
        logic       is_wr;
        logic       is_halt;
        logic [1:0] alu_op;
        logic [1:0] acc_src;
    } op_info_t;

endpackage

// File: rtl/cpu_opcode_decoder.sv
// rtl/cpu_opcode_decoder.sv - combinational opcode classification for the sequencer
module cpu_opcode_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output op_info_t   info
);

    always_comb begin
        info = '0;
        case (opcode)
            OP_LDA: begin
                info.is_mem  = 1'b1;
                info.acc_src = SRC_MEM;
            end
            OP_ADD: begin
                info.is_mem  = 1'b1;
                info.acc_src = SRC_ALU;
                info.alu_op  = ALU_ADD;
            end
            OP_SUB: begin
                info.is_mem  = 1'b1;
                info.acc_src = SRC_ALU;
                info.alu_op  = ALU_SUB;
            end
            OP_STA: begin
                info.is_mem = 1'b1;
                info.is_wr  = 1'b1;
            end
            OP_LDI:  info.acc_src = SRC_IMM;
            OP_HLT:  info.is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// rtl/cpu_ctrl_seq.sv - multi-cycle FETCH/DECODE/MEM/EXEC sequencer with retired-instruction counter
module cpu_ctrl_seq
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [7:0]       instr,
    input  logic             zero_flag,
    input  logic             mem_ready,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             ir_load,
    output logic             addr_sel,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             acc_load,
    output logic [1:0]       acc_src,
    output logic [1:0]       alu_op,
    output logic             out_load,
    output logic             halted,
    output logic [2:0]       state_dbg,
    output logic [CNT_W-1:0] retired
);

    logic [2:0] state;
    logic [2:0] state_next;
    logic       fetch_busy;
    logic       retire;
    op_info_t   info;
    logic       unused_operand;

    assign unused_operand = ^instr[3:0];
    assign state_dbg      = state;

    cpu_opcode_decoder u_decoder (
        .opcode (instr[7:4]),
        .info   (info)
    );

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        ir_load    = 1'b0;
        addr_sel   = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        acc_load   = 1'b0;
        acc_src    = SRC_MEM;
        alu_op     = ALU_PASS;
        out_load   = 1'b0;
        halted     = 1'b0;
        case (state)
            ST_IDLE: if (run) state_next = ST_FETCH;
            ST_FETCH: begin
                // run only matters on entry; a fetch already waiting on memory is finished
                if (fetch_busy || run) begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        ir_load    = 1'b1;
                        pc_inc     = 1'b1;
                        state_next = ST_DECODE;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (info.is_halt) begin
                    state_next = ST_HALT;
                    retire     = 1'b1;
                end else if (info.is_mem) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_MEM: begin
                addr_sel = 1'b1;
                mem_wr   = info.is_wr;
                mem_rd   = ~info.is_wr;
                if (mem_ready) begin
                    state_next = ST_FETCH;
                    retire     = 1'b1;
                    if (!info.is_wr) begin
                        acc_load = 1'b1;
                        acc_src  = info.acc_src;
                        alu_op   = info.alu_op;
                    end
                end
            end
            ST_EXEC: begin
                state_next = ST_FETCH;
                retire     = 1'b1;
                case (instr[7:4])
                    OP_LDI: begin
                        acc_load = 1'b1;
                        acc_src  = SRC_IMM;
                    end
                    OP_JMP:  pc_load  = 1'b1;
                    OP_JZ:   pc_load  = zero_flag;
                    OP_OUT:  out_load = 1'b1;
                    default: ;
                endcase
            end
            ST_HALT: halted = 1'b1;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            fetch_busy <= 1'b0;
            retired    <= '0;
        end else begin
            state      <= state_next;
            fetch_busy <= (state == ST_FETCH) && mem_rd && !mem_ready;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb/tb_cpu_ctrl_seq.sv - randomized self-checking bench against an instruction-level reference model
module tb_cpu_ctrl_seq;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic [7:0]       instr;
    logic             zero_flag;
    logic             mem_ready;
    logic             pc_inc, pc_load, ir_load, addr_sel, mem_rd, mem_wr;
    logic             acc_load, out_load, halted;
    logic [1:0]       acc_src, alu_op;
    logic [2:0]       state_dbg;
    logic [CNT_W-1:0] retired;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    cpu_ctrl_seq #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .instr     (instr),
        .zero_flag (zero_flag),
        .mem_ready (mem_ready),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .ir_load   (ir_load),
        .addr_sel  (addr_sel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .acc_load  (acc_load),
        .acc_src   (acc_src),
        .alu_op    (alu_op),
        .out_load  (out_load),
        .halted    (halted),
        .state_dbg (state_dbg),
        .retired   (retired)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [12:0] strb(logic pi, logic pl, logic il, logic as, logic rd, logic wr,
                                         logic al, logic [1:0] src, logic [1:0] aop, logic ol, logic h);
        return {pi, pl, il, as, rd, wr, al, src, aop, ol, h};
    endfunction

    task automatic expect_out(input string tag, input logic [12:0] s, input logic [2:0] st);
        check({tag, "_strobes"}, {pc_inc, pc_load, ir_load, addr_sel, mem_rd, mem_wr, acc_load,
                                  acc_src, alu_op, out_load, halted}, s);
        check({tag, "_state"}, state_dbg, st);
        check({tag, "_retired"}, retired, exp_ret);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_retired();
        exp_ret = (exp_ret + 1) % (1 << CNT_W);
    endtask

    // Called in the first FETCH cycle; with run low the sequencer must park in IDLE until run returns.
    task automatic ensure_fetch();
        if (!run) begin
            mem_ready = 1'($urandom_range(0, 1));
            #1 expect_out("fetch_norun", '0, 3'd1);
            step();
            #1 expect_out("idle", '0, 3'd0);
            repeat ($urandom_range(0, 2)) begin
                step();
                #1 expect_out("idle_hold", '0, 3'd0);
            end
            step();
            run = 1'b1;
            #1 expect_out("idle_go", '0, 3'd0);
            step();
        end
    endtask

    // run_mode: 0 = run held, 1 = run dropped in DECODE, 2 = run randomized after the fetch starts
    task automatic do_instr(input logic [7:0] ins, input int fstall, input int mstall,
                            input logic zf, input int run_mode);
        logic [3:0] op;
        logic       rdy, al, pl;
        logic [1:0] src, aop;
        op = ins[7:4];
        ensure_fetch();
        instr = ins;
        zero_flag = zf;
        for (int i = 0; i <= fstall; i++) begin
            rdy = (i == fstall);
            mem_ready = rdy;
            if (i > 0 && run_mode == 2) run = 1'($urandom_range(0, 1));
            #1 expect_out("fetch", strb(rdy, 0, rdy, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0), 3'd1);
            step();
        end
        mem_ready = 1'($urandom_range(0, 1));
        if (run_mode == 1) run = 1'b0;
        if (run_mode == 2) run = 1'($urandom_range(0, 1));
        #1 expect_out("decode", '0, 3'd2);
        step();
        if (op == 4'hF) begin
            bump_retired();
        end else if (op >= 4'h1 && op <= 4'h4) begin
            for (int j = 0; j <= mstall; j++) begin
                rdy = (j == mstall);
                mem_ready = rdy;
                if (run_mode == 2) run = 1'($urandom_range(0, 1));
                al  = rdy && (op != 4'h4);
                src = !al ? 2'd0 : (op == 4'h1) ? 2'd0 : 2'd1;
                aop = !al ? 2'd0 : (op == 4'h2) ? 2'd1 : (op == 4'h3) ? 2'd2 : 2'd0;
                #1 expect_out("mem", strb(0, 0, 0, 1, op != 4'h4, op == 4'h4, al, src, aop, 0, 0), 3'd3);
                step();
            end
            bump_retired();
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
            if (run_mode == 2) run = 1'($urandom_range(0, 1));
            pl = (op == 4'h6) || (op == 4'h7 && zf);
            #1 expect_out("exec", strb(0, pl, 0, 0, 0, 0, op == 4'h5, (op == 4'h5) ? 2'd2 : 2'd0,
                                       2'd0, op == 4'h8, 0), 3'd4);
            step();
            bump_retired();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        instr = 8'h00;
        zero_flag = 1'b0;
        mem_ready = 1'b0;
        repeat (2) step();
        #1 expect_out("reset", '0, 3'd0);
        step();
        rst_n = 1'b1;
        run = 1'b1;
        #1 expect_out("idle_start", '0, 3'd0);
        step();

        do_instr(8'h53, 0, 0, 1'b0, 0);
        check("ldi_retired", retired, 1);
        do_instr(8'h2A, 0, 2, 1'b0, 0);
        do_instr(8'h7C, 0, 0, 1'b1, 0);
        do_instr(8'h7C, 1, 0, 1'b0, 0);
        do_instr(8'h45, 0, 1, 1'b0, 0);
        do_instr(8'h00, 0, 0, 1'b0, 1);
        do_instr(8'h53, 0, 0, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            logic [7:0] ins;
            ins = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
            do_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), 2);
            if (exp_ret == 0) check("retired_wrap", retired, 0);
        end

        // Abort an ADD while its memory access is stalled
        ensure_fetch();
        instr = 8'h2A;
        mem_ready = 1'b1;
        #1 expect_out("abort_fetch", strb(1, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0), 3'd1);
        step();
        #1 expect_out("abort_decode", '0, 3'd2);
        step();
        mem_ready = 1'b0;
        #1 expect_out("abort_mem", strb(0, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0), 3'd3);
        step();
        rst_n = 1'b0;
        exp_ret = 0;
        #1 expect_out("abort_reset", '0, 3'd0);
        step();
        rst_n = 1'b1;
        run = 1'b1;
        #1 expect_out("abort_idle", '0, 3'd0);
        step();

        do_instr(8'h45, 0, 0, 1'b0, 0);
        do_instr(8'hF0, 1, 0, 1'b0, 0);
        repeat (6) begin
            run = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            #1 expect_out("halt", strb(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1), 3'd5);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
